// File: rtl/bp_be_br_resolver.sv
// Branch resolver: compares resolved next-PC with the predicted next-PC, flushes and
// redirects the frontend on a mispredict, and blanks wrong-path resolutions until refill.
module bp_be_br_resolver #(
    parameter int vaddr_width_p  = 39,
    parameter int drain_cycles_p = 2,
    parameter int cnt_width_p    = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     resolve_v_i,
    input  logic                     resolve_br_i,
    input  logic [vaddr_width_p-1:0] resolve_tgt_i,
    input  logic [vaddr_width_p-1:0] pred_npc_i,
    output logic                     flush_o,
    output logic                     misalign_v_o,
    output logic                     redirect_v_o,
    output logic [vaddr_width_p-1:0] redirect_pc_o,
    input  logic                     redirect_ready_i,
    output logic                     busy_o,
    output logic [cnt_width_p-1:0]   branch_cnt_o,
    output logic [cnt_width_p-1:0]   mispred_cnt_o,
    output logic [cnt_width_p-1:0]   squash_cnt_o
);

    localparam int drain_w_lp = (drain_cycles_p > 0) ? $clog2(drain_cycles_p + 1) : 1;
    localparam logic [drain_w_lp-1:0] drain_one_lp  = drain_w_lp'(1);
    localparam logic [drain_w_lp-1:0] drain_load_lp = drain_w_lp'(drain_cycles_p);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [drain_w_lp-1:0]    drain_cnt_q, drain_cnt_d;
    logic                     flush_q, flush_d;
    logic                     misalign_q, misalign_d;
    logic                     redirect_v_q, redirect_v_d;
    logic [vaddr_width_p-1:0] redirect_pc_q, redirect_pc_d;
    logic                     busy_q, busy_d;
    logic [cnt_width_p-1:0]   branch_cnt_q, mispred_cnt_q, squash_cnt_q;
    logic                     br_inc_s, mispred_inc_s, squash_inc_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] val,
                                                        input logic                   en);
        if (en && (val != {cnt_width_p{1'b1}})) begin
            sat_inc = val + cnt_width_p'(1);
        end else begin
            sat_inc = val;
        end
    endfunction

    // Next-state, redirect and counter-enable decode.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;
        redirect_v_d  = redirect_v_q;
        redirect_pc_d = redirect_pc_q;
        br_inc_s      = 1'b0;
        mispred_inc_s = 1'b0;
        squash_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (resolve_v_i) begin
                    br_inc_s = resolve_br_i;
                    if (resolve_tgt_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else if (resolve_tgt_i != pred_npc_i) begin
                        flush_d       = 1'b1;
                        redirect_v_d  = 1'b1;
                        redirect_pc_d = resolve_tgt_i;
                        mispred_inc_s = 1'b1;
                        state_d       = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                // Anything resolving while a redirect is outstanding is wrong-path.
                squash_inc_s = resolve_v_i;
                if (redirect_ready_i) begin
                    redirect_v_d = 1'b0;
                    if (drain_cycles_p == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = drain_load_lp;
                    end
                end else begin
                    redirect_v_d = 1'b1;
                end
            end
            DRAIN: begin
                squash_inc_s = resolve_v_i;
                if (drain_cnt_q <= drain_one_lp) begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - drain_one_lp;
                end
            end
            default: begin
                state_d      = IDLE;
                redirect_v_d = 1'b0;
                drain_cnt_d  = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, registered outputs and statistics counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            drain_cnt_q   <= '0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            redirect_v_q  <= 1'b0;
            redirect_pc_q <= '0;
            busy_q        <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            squash_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
            redirect_v_q  <= redirect_v_d;
            redirect_pc_q <= redirect_pc_d;
            busy_q        <= busy_d;
            branch_cnt_q  <= sat_inc(branch_cnt_q, br_inc_s);
            mispred_cnt_q <= sat_inc(mispred_cnt_q, mispred_inc_s);
            squash_cnt_q  <= sat_inc(squash_cnt_q, squash_inc_s);
        end
    end

    assign flush_o       = flush_q;
    assign misalign_v_o  = misalign_q;
    assign redirect_v_o  = redirect_v_q;
    assign redirect_pc_o = redirect_pc_q;
    assign busy_o        = busy_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
    assign squash_cnt_o  = squash_cnt_q;

endmodule

// File: tb/tb_bp_be_br_resolver.sv
// Bench for bp_be_br_resolver: directed scenarios plus a randomized run against a
// cycle-level behavioural model, on a drain=2 instance and a drain=0 / 3-bit-counter instance.
module tb_bp_be_br_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_v, res_br, rdy;
    logic [38:0] res_tgt, pred;

    logic        flush, mis, rv, busy;
    logic [38:0] rpc;
    logic [31:0] bcnt, mcnt, scnt;

    logic        flush0, mis0, rv0, busy0;
    logic [38:0] rpc0;
    logic [2:0]  bcnt0, mcnt0, scnt0;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    bp_be_br_resolver #(.vaddr_width_p(39), .drain_cycles_p(2), .cnt_width_p(32)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .resolve_v_i(res_v), .resolve_br_i(res_br),
        .resolve_tgt_i(res_tgt), .pred_npc_i(pred), .flush_o(flush), .misalign_v_o(mis),
        .redirect_v_o(rv), .redirect_pc_o(rpc), .redirect_ready_i(rdy), .busy_o(busy),
        .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt), .squash_cnt_o(scnt));

    bp_be_br_resolver #(.vaddr_width_p(39), .drain_cycles_p(0), .cnt_width_p(3)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .resolve_v_i(res_v), .resolve_br_i(res_br),
        .resolve_tgt_i(res_tgt), .pred_npc_i(pred), .flush_o(flush0), .misalign_v_o(mis0),
        .redirect_v_o(rv0), .redirect_pc_o(rpc0), .redirect_ready_i(1'b1), .busy_o(busy0),
        .branch_cnt_o(bcnt0), .mispred_cnt_o(mcnt0), .squash_cnt_o(scnt0));

    // Reference model state, index 0 = dut, 1 = dut0.
    bit          m_pend[2];
    int          m_blank[2];
    logic [38:0] m_pc[2];
    bit          e_flush[2], e_mis[2];
    longint      c_br[2], c_mp[2], c_sq[2];
    longint      cap[2];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic br, input logic [38:0] t, input logic [38:0] p);
        res_v = v; res_br = br; res_tgt = t; pred = p;
    endtask

    function automatic longint sat(input longint v, input longint c);
        return (v < c) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 0; m_blank[m] = 0; m_pc[m] = '0; e_flush[m] = 0; e_mis[m] = 0;
            c_br[m] = 0; c_mp[m] = 0; c_sq[m] = 0;
        end
    endtask

    // One rising edge of the model: an outstanding redirect or a running blank window makes
    // the current resolution wrong-path; otherwise the resolution is judged on its own.
    task automatic model_step(input int m, input int drain, input bit ready);
        bit wrong_path;
        wrong_path = m_pend[m] || (m_blank[m] != 0);
        e_flush[m] = 0;
        e_mis[m]   = 0;
        if (m_pend[m]) begin
            if (ready) begin m_pend[m] = 0; m_blank[m] = drain; end
        end else if (m_blank[m] != 0) begin
            m_blank[m] = m_blank[m] - 1;
        end
        if (res_v) begin
            if (wrong_path) begin
                c_sq[m] = sat(c_sq[m], cap[m]);
            end else begin
                if (res_br) c_br[m] = sat(c_br[m], cap[m]);
                if (res_tgt[1:0] != 2'b00) begin
                    e_mis[m] = 1;
                end else if (res_tgt != pred) begin
                    e_flush[m] = 1; m_pend[m] = 1; m_pc[m] = res_tgt;
                    c_mp[m] = sat(c_mp[m], cap[m]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b0;
        drive(1'b0, 1'b0, 39'd0, 39'd0);
        repeat (2) @(negedge clk);
        vec++; if (flush !== 1'b0) begin errs++; $display("FAIL reset_flush got %0h exp 0", flush); end
        vec++; if (mis !== 1'b0) begin errs++; $display("FAIL reset_mis got %0h exp 0", mis); end
        vec++; if (rv !== 1'b0) begin errs++; $display("FAIL reset_rv got %0h exp 0", rv); end
        vec++; if (rpc !== 39'd0) begin errs++; $display("FAIL reset_rpc got %0h exp 0", rpc); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0h exp 0", busy); end
        vec++; if ({bcnt, mcnt, scnt} !== 96'd0) begin errs++; $display("FAIL reset_cnts got %0h/%0h/%0h exp 0", bcnt, mcnt, scnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_correct();
        drive(1'b1, 1'b1, 39'h8000_0010, 39'h8000_0010);
        tick();
        res_v = 1'b0;
        vec++; if (flush !== 1'b0) begin errs++; $display("FAIL correct_flush got %0h exp 0", flush); end
        vec++; if (rv !== 1'b0) begin errs++; $display("FAIL correct_rv got %0h exp 0", rv); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL correct_busy got %0h exp 0", busy); end
        vec++; if (bcnt !== 32'd1) begin errs++; $display("FAIL correct_bcnt got %0d exp 1", bcnt); end
        vec++; if (mcnt !== 32'd0) begin errs++; $display("FAIL correct_mcnt got %0d exp 0", mcnt); end
    endtask

    task automatic test_mispredict_stall();
        rdy = 1'b0;
        drive(1'b1, 1'b1, 39'h8000_0100, 39'h8000_0004);
        tick();
        res_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vec++; if (rv !== 1'b1) begin errs++; $display("FAIL stall_rv cyc %0d got %0h exp 1", i, rv); end
            vec++; if (rpc !== 39'h8000_0100) begin errs++; $display("FAIL stall_rpc cyc %0d got %0h exp 8000_0100", i, rpc); end
            vec++; if (flush !== (i == 0)) begin errs++; $display("FAIL stall_flush cyc %0d got %0h exp %0h", i, flush, (i == 0)); end
            vec++; if (busy !== 1'b1) begin errs++; $display("FAIL stall_busy cyc %0d got %0h exp 1", i, busy); end
            rdy = (i == 3);
            tick();
        end
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vec++; if (rv !== 1'b0) begin errs++; $display("FAIL drain_rv cyc %0d got %0h exp 0", i, rv); end
            vec++; if (busy !== 1'b1) begin errs++; $display("FAIL drain_busy cyc %0d got %0h exp 1", i, busy); end
            tick();
        end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL stall_idle_busy got %0h exp 0", busy); end
        vec++; if (bcnt !== 32'd2) begin errs++; $display("FAIL stall_bcnt got %0d exp 2", bcnt); end
        vec++; if (mcnt !== 32'd1) begin errs++; $display("FAIL stall_mcnt got %0d exp 1", mcnt); end
    endtask

    task automatic test_squash();
        rdy = 1'b0;
        drive(1'b1, 1'b1, 39'h8000_0200, 39'h8000_0204);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 39'h8000_1000 + 39'(i * 8), 39'h8000_2000);
            rdy = (i == 2);
            tick();
            vec++; if (flush !== 1'b0) begin errs++; $display("FAIL squash_flush cyc %0d got %0h exp 0", i, flush); end
        end
        res_v = 1'b0; rdy = 1'b0;
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL squash_busy got %0h exp 0", busy); end
        vec++; if (scnt !== 32'd5) begin errs++; $display("FAIL squash_scnt got %0d exp 5", scnt); end
        vec++; if (bcnt !== 32'd3) begin errs++; $display("FAIL squash_bcnt got %0d exp 3", bcnt); end
        vec++; if (mcnt !== 32'd2) begin errs++; $display("FAIL squash_mcnt got %0d exp 2", mcnt); end
        tick();
        vec++; if (rv !== 1'b0) begin errs++; $display("FAIL squash_rv got %0h exp 0", rv); end
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 39'h8000_0102, 39'h8000_0004);
        tick();
        res_v = 1'b0;
        vec++; if (mis !== 1'b1) begin errs++; $display("FAIL misalign_pulse got %0h exp 1", mis); end
        vec++; if (rv !== 1'b0) begin errs++; $display("FAIL misalign_rv got %0h exp 0", rv); end
        vec++; if (flush !== 1'b0) begin errs++; $display("FAIL misalign_flush got %0h exp 0", flush); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL misalign_busy got %0h exp 0", busy); end
        tick();
        vec++; if (mis !== 1'b0) begin errs++; $display("FAIL misalign_end got %0h exp 0", mis); end
        vec++; if (bcnt !== 32'd3) begin errs++; $display("FAIL misalign_bcnt got %0d exp 3", bcnt); end
        vec++; if (mcnt !== 32'd2) begin errs++; $display("FAIL misalign_mcnt got %0d exp 2", mcnt); end
    endtask

    task automatic test_reset_mid_send();
        rdy = 1'b0;
        drive(1'b1, 1'b1, 39'h8000_0300, 39'h8000_0000);
        tick();
        res_v = 1'b0;
        vec++; if (rv !== 1'b1) begin errs++; $display("FAIL midrst_pre_rv got %0h exp 1", rv); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (rv !== 1'b0) begin errs++; $display("FAIL midrst_rv got %0h exp 0", rv); end
        vec++; if (rpc !== 39'd0) begin errs++; $display("FAIL midrst_rpc got %0h exp 0", rpc); end
        vec++; if ({bcnt, mcnt, scnt} !== 96'd0) begin errs++; $display("FAIL midrst_cnts got %0h/%0h/%0h exp 0", bcnt, mcnt, scnt); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 39'h8000_0400, 39'h8000_0400);
        tick();
        res_v = 1'b0;
        vec++; if (rv !== 1'b0) begin errs++; $display("FAIL midrst_after_rv got %0h exp 0", rv); end
        vec++; if (flush !== 1'b0) begin errs++; $display("FAIL midrst_after_flush got %0h exp 0", flush); end
        vec++; if (bcnt !== 32'd1) begin errs++; $display("FAIL midrst_after_bcnt got %0d exp 1", bcnt); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 39'h8000_0500, 39'h8000_0504);
        tick();
        res_v = 1'b0;
        vec++; if (rv0 !== 1'b1) begin errs++; $display("FAIL b2b_rv_a got %0h exp 1", rv0); end
        vec++; if (flush0 !== 1'b1) begin errs++; $display("FAIL b2b_flush_a got %0h exp 1", flush0); end
        vec++; if (rpc0 !== 39'h8000_0500) begin errs++; $display("FAIL b2b_rpc_a got %0h exp 8000_0500", rpc0); end
        tick();
        vec++; if (rv0 !== 1'b0) begin errs++; $display("FAIL b2b_rv_gap got %0h exp 0", rv0); end
        vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL b2b_busy_gap got %0h exp 0", busy0); end
        drive(1'b1, 1'b0, 39'h8000_0600, 39'h8000_0604);
        tick();
        res_v = 1'b0;
        vec++; if (rv0 !== 1'b1) begin errs++; $display("FAIL b2b_rv_b got %0h exp 1", rv0); end
        vec++; if (rpc0 !== 39'h8000_0600) begin errs++; $display("FAIL b2b_rpc_b got %0h exp 8000_0600", rpc0); end
        vec++; if (mcnt0 !== 3'd2) begin errs++; $display("FAIL b2b_mcnt got %0d exp 2", mcnt0); end
        vec++; if (scnt0 !== 3'd0) begin errs++; $display("FAIL b2b_scnt got %0d exp 0", scnt0); end
        tick();
        vec++; if (rv0 !== 1'b0) begin errs++; $display("FAIL b2b_rv_end got %0h exp 0", rv0); end
    endtask

    task automatic test_random();
        logic [63:0] r64, s64;
        rst_n = 1'b0; rdy = 1'b0;
        drive(1'b0, 1'b0, 39'd0, 39'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            r64 = {$urandom, $urandom};
            s64 = {$urandom, $urandom};
            pred = {r64[38:2], 2'b00};
            case ($urandom_range(0, 3))
                0: res_tgt = pred;
                1: res_tgt = pred + 39'd4;
                2: res_tgt = pred + 39'($urandom_range(1, 3));
                default: res_tgt = s64[38:0];
            endcase
            res_v  = ($urandom_range(0, 9) < 6);
            res_br = $urandom_range(0, 1);
            rdy    = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_step(0, 2, rdy);
            model_step(1, 0, 1'b1);
            @(negedge clk);
            vec++; if (flush !== e_flush[0]) begin errs++; $display("FAIL rnd_flush n=%0d got %0h exp %0h", n, flush, e_flush[0]); end
            vec++; if (mis !== e_mis[0]) begin errs++; $display("FAIL rnd_mis n=%0d got %0h exp %0h", n, mis, e_mis[0]); end
            vec++; if (rv !== m_pend[0]) begin errs++; $display("FAIL rnd_rv n=%0d got %0h exp %0h", n, rv, m_pend[0]); end
            vec++; if (rpc !== m_pc[0]) begin errs++; $display("FAIL rnd_rpc n=%0d got %0h exp %0h", n, rpc, m_pc[0]); end
            vec++; if (busy !== (m_pend[0] || m_blank[0] != 0)) begin errs++; $display("FAIL rnd_busy n=%0d got %0h", n, busy); end
            vec++; if ({bcnt, mcnt, scnt} !== {c_br[0][31:0], c_mp[0][31:0], c_sq[0][31:0]}) begin errs++; $display("FAIL rnd_cnts n=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", n, bcnt, mcnt, scnt, c_br[0], c_mp[0], c_sq[0]); end
            vec++; if (flush0 !== e_flush[1]) begin errs++; $display("FAIL rnd0_flush n=%0d got %0h exp %0h", n, flush0, e_flush[1]); end
            vec++; if (mis0 !== e_mis[1]) begin errs++; $display("FAIL rnd0_mis n=%0d got %0h exp %0h", n, mis0, e_mis[1]); end
            vec++; if (rv0 !== m_pend[1]) begin errs++; $display("FAIL rnd0_rv n=%0d got %0h exp %0h", n, rv0, m_pend[1]); end
            vec++; if (rpc0 !== m_pc[1]) begin errs++; $display("FAIL rnd0_rpc n=%0d got %0h exp %0h", n, rpc0, m_pc[1]); end
            vec++; if (busy0 !== (m_pend[1] || m_blank[1] != 0)) begin errs++; $display("FAIL rnd0_busy n=%0d got %0h", n, busy0); end
            vec++; if ({bcnt0, mcnt0, scnt0} !== {c_br[1][2:0], c_mp[1][2:0], c_sq[1][2:0]}) begin errs++; $display("FAIL rnd0_cnts n=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", n, bcnt0, mcnt0, scnt0, c_br[1], c_mp[1], c_sq[1]); end
        end
        res_v = 1'b0;
    endtask

    initial begin
        cap[0] = 64'hFFFF_FFFF;
        cap[1] = 7;
        test_reset();
        test_correct();
        test_mispredict_stall();
        test_squash();
        test_misalign();
        test_reset_mid_send();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
